// File: rtl/pipe_pkg.sv
// pipe_pkg -- constants shared by the RV32I pipeline stages.
//   XLEN       datapath width
//   REG_IDX_W  architectural register index width
//   resultSrc_e  write-back result select encodings (2'b11 is reserved; decoders treat it as ALU)
// Build option used by importers: WB_REGFILE_BYPASS_EN (see regfile_2r1w).
package pipe_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } resultSrc_e;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if -- W-stage inputs, decode read ports and write-back outputs of wb_regfile.
//   master : pipeline side; drives validW, regWriteW, ResultSrcW, aluResultW, readDataW,
//            PC_plus_4W, rdW, rs1D, rs2D; observes rd1D, rd2D, resultW, instretW.
//   slave  : wb_regfile side, directions mirrored.
// rdW is a full 32-bit field; only [4:0] are meaningful.
interface wb_regfile_if #(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int CNT_W = 64
);

  logic                 validW;
  logic                 regWriteW;
  logic [1:0]           ResultSrcW;
  logic [XLEN-1:0]      aluResultW;
  logic [XLEN-1:0]      readDataW;
  logic [XLEN-1:0]      PC_plus_4W;
  logic [31:0]          rdW;
  logic [pipe_pkg::REG_IDX_W-1:0] rs1D;
  logic [pipe_pkg::REG_IDX_W-1:0] rs2D;
  logic [XLEN-1:0]      rd1D;
  logic [XLEN-1:0]      rd2D;
  logic [XLEN-1:0]      resultW;
  logic [CNT_W-1:0]     instretW;

  modport master (
    output validW, regWriteW, ResultSrcW, aluResultW, readDataW, PC_plus_4W, rdW, rs1D, rs2D,
    input  rd1D, rd2D, resultW, instretW
  );

  modport slave (
    input  validW, regWriteW, ResultSrcW, aluResultW, readDataW, PC_plus_4W, rdW, rs1D, rs2D,
    output rd1D, rd2D, resultW, instretW
  );

endinterface

// File: rtl/regfile_2r1w.sv
// regfile_2r1w -- architectural register file, two combinational read ports, one write port.
//   CLK, RST_N      clock, asynchronous active-low reset (clears every entry)
//   we, wAddr, wData  write port, committed on the rising edge
//   rAddr1/rData1, rAddr2/rData2  read ports, index 0 always reads 0
// Build option WB_REGFILE_BYPASS_EN: a read matching the in-flight write returns wData
// in the same cycle. Without it, reads show the stored (pre-edge) value.
module regfile_2r1w
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int IDX_W = REG_IDX_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             we,
  input  logic [IDX_W-1:0] wAddr,
  input  logic [XLEN-1:0]  wData,
  input  logic [IDX_W-1:0] rAddr1,
  input  logic [IDX_W-1:0] rAddr2,
  output logic [XLEN-1:0]  rData1,
  output logic [XLEN-1:0]  rData2
);

  logic [XLEN-1:0] mem [NREGS];
  logic            weEff;

  // x0 is enforced here as well so the array never depends on the caller's guard.
  assign weEff = we && (wAddr != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (weEff) begin
      mem[wAddr] <= wData;
    end
  end

`ifdef WB_REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Bypass is suppressed while reset is held so the read ports stay at 0.
  assign byp1 = weEff && RST_N && (rAddr1 == wAddr);
  assign byp2 = weEff && RST_N && (rAddr2 == wAddr);

  assign rData1 = (rAddr1 == '0) ? '0 : (byp1 ? wData : mem[rAddr1]);
  assign rData2 = (rAddr2 == '0) ? '0 : (byp2 ? wData : mem[rAddr2]);
`else
  assign rData1 = (rAddr1 == '0) ? '0 : mem[rAddr1];
  assign rData2 = (rAddr2 == '0) ? '0 : mem[rAddr2];
`endif

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and architectural register file of the 5-stage RV32I pipe.
//   CLK, RST_N  pipeline clock, asynchronous active-low reset
//   bus (wb_regfile_if.slave):
//     validW, regWriteW, ResultSrcW, aluResultW, readDataW, PC_plus_4W, rdW  W-stage inputs
//     rs1D, rs2D -> rd1D, rd2D   decode read ports (combinational)
//     resultW                    selected write-back value, also feeds EX forwarding
//     instretW                   retired-instruction count, wraps silently
// Build option WB_REGFILE_BYPASS_EN: same-cycle write-through on the read ports.
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int XLEN  = pipe_pkg::XLEN,
  parameter int NREGS = 32,
  parameter int CNT_W = 64
) (
  input logic        CLK,
  input logic        RST_N,
  wb_regfile_if.slave bus
);

  logic [XLEN-1:0]      resultW;
  logic [REG_IDX_W-1:0] rdIdx;
  logic                 we;
  logic [CNT_W-1:0]     instret;
  logic                 unusedRdHi;

  assign rdIdx      = bus.rdW[REG_IDX_W-1:0];
  assign unusedRdHi = ^bus.rdW[31:REG_IDX_W];

  // Reserved encoding 2'b11 falls through to the ALU result.
  always_comb begin
    resultW = bus.aluResultW;
    case (bus.ResultSrcW)
      RES_MEM: resultW = bus.readDataW;
      RES_PC4: resultW = bus.PC_plus_4W;
      default: resultW = bus.aluResultW;
    endcase
  end

  assign we = bus.validW && bus.regWriteW && (rdIdx != '0);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .IDX_W (REG_IDX_W)
  ) uRegfile (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .we     (we),
    .wAddr  (rdIdx),
    .wData  (resultW),
    .rAddr1 (bus.rs1D),
    .rAddr2 (bus.rs2D),
    .rData1 (bus.rd1D),
    .rData2 (bus.rd2D)
  );

  // Every valid W-stage instruction retires, whether or not it writes rd.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instret <= '0;
    end else if (bus.validW) begin
      instret <= instret + CNT_W'(1);
    end
  end

  assign bus.resultW  = resultW;
  assign bus.instretW = instret;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic CLK;
  logic RST_N;

  wb_regfile_if bus ();

  wb_regfile dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        valid;
    logic        regWrite;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc4;
    logic [31:0] rd;
    logic [31:0] expResult;
  } vec_t;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] val;
  } exp_t;

  vec_t        vecs [12];
  exp_t        sbq [$];
  logic [31:0] modelRegs [32];
  logic [63:0] modelInstret;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic driveIdle();
    bus.validW     = 1'b0;
    bus.regWriteW  = 1'b0;
    bus.ResultSrcW = 2'b00;
    bus.aluResultW = '0;
    bus.readDataW  = '0;
    bus.PC_plus_4W = '0;
    bus.rdW        = '0;
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) modelRegs[i] = '0;
    modelInstret = '0;
  endtask

  task automatic readBoth(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    bus.rs1D = idx;
    bus.rs2D = idx;
    #1;
    check($sformatf("%s_rd1_x%0d", tag, idx), 64'(bus.rd1D), 64'(exp));
    check($sformatf("%s_rd2_x%0d", tag, idx), 64'(bus.rd2D), 64'(exp));
  endtask

  initial begin
    exp_t        e;
    logic        modelWe;
    logic [4:0]  idx;
    logic [31:0] stale;

    checks = 0;
    errors = 0;
    resetModel();
    driveIdle();
    bus.rs1D = '0;
    bus.rs2D = '0;

    //        valid regWr src    alu            mem            pc4            rd             expResult
    vecs[0]  = '{1'b1, 1'b1, 2'b00, 32'hDEADBEEF, 32'h0,        32'h0,        32'd5,         32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b1, 2'b00, 32'h12345678, 32'h0,        32'h0,        32'd0,         32'h12345678};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 32'h00001111, 32'hA5A5A5A5, 32'h00002222, 32'd7,         32'hA5A5A5A5};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 32'h00001111, 32'h00003333, 32'h00000104, 32'd8,         32'h00000104};
    vecs[4]  = '{1'b1, 1'b1, 2'b11, 32'h00000077, 32'h00000099, 32'h00000055, 32'd9,         32'h00000077};
    vecs[5]  = '{1'b1, 1'b1, 2'b00, 32'h00000001, 32'h0,        32'h0,        32'd10,        32'h00000001};
    vecs[6]  = '{1'b1, 1'b1, 2'b01, 32'h0,        32'h00000033, 32'h0,        32'd3,         32'h00000033};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 32'h00003333, 32'h0,        32'h0,        32'd3,         32'h00003333};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 32'h00004444, 32'h0,        32'h0,        32'd4,         32'h00004444};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h00000066, 32'h0,        32'h0,        32'hFFFFFFE6,  32'h00000066};
    vecs[10] = '{1'b1, 1'b1, 2'b10, 32'h0,        32'h0,        32'hFFFFFFFF, 32'd31,        32'hFFFFFFFF};
    vecs[11] = '{1'b1, 1'b1, 2'b00, 32'h0000ABCD, 32'h0,        32'h0,        32'd5,         32'h0000ABCD};

    // Reset held from time 0, released between edges.
    RST_N = 1'b0;
    #2;
    readBoth(5'd5, 32'h0, "rst_held");
    check("rst_held_instret", bus.instretW, 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rs1D = 5'(i);
      bus.rs2D = 5'(31 - i);
      #1;
      check($sformatf("post_rst_rd1_x%0d", i), 64'(bus.rd1D), 64'h0);
      check($sformatf("post_rst_rd2_x%0d", 31 - i), 64'(bus.rd2D), 64'h0);
    end
    check("post_rst_instret", bus.instretW, 64'h0);

    // Table-driven vectors with the scoreboard holding the expected destination contents.
    @(posedge CLK);
    #1;
    for (int v = 0; v < 12; v++) begin
      bus.validW     = vecs[v].valid;
      bus.regWriteW  = vecs[v].regWrite;
      bus.ResultSrcW = vecs[v].src;
      bus.aluResultW = vecs[v].alu;
      bus.readDataW  = vecs[v].mem;
      bus.PC_plus_4W = vecs[v].pc4;
      bus.rdW        = vecs[v].rd;
      @(negedge CLK);
      check($sformatf("vec%0d_resultW", v), 64'(bus.resultW), 64'(vecs[v].expResult));
      idx     = vecs[v].rd[4:0];
      modelWe = vecs[v].valid && vecs[v].regWrite && (idx != 5'd0);
      if (modelWe) modelRegs[idx] = vecs[v].expResult;
      if (vecs[v].valid) modelInstret = modelInstret + 64'd1;
      e.idx = idx;
      e.val = modelRegs[idx];
      sbq.push_back(e);
      @(posedge CLK);
      #1;
      driveIdle();
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        readBoth(e.idx, e.val, $sformatf("vec%0d", v));
      end
      check($sformatf("vec%0d_instret", v), bus.instretW, modelInstret);
    end

    // Same-cycle write and read of x10 (currently 0x1).
    stale = modelRegs[10];
    bus.validW     = 1'b1;
    bus.regWriteW  = 1'b1;
    bus.ResultSrcW = 2'b00;
    bus.aluResultW = 32'hCAFEF00D;
    bus.rdW        = 32'd10;
    bus.rs1D       = 5'd10;
    bus.rs2D       = 5'd0;
    @(negedge CLK);
`ifdef WB_REGFILE_BYPASS_EN
    check("samecyc_rd1_x10", 64'(bus.rd1D), 64'hCAFEF00D);
`else
    check("samecyc_rd1_x10", 64'(bus.rd1D), 64'(stale));
`endif
    check("samecyc_rd2_x0", 64'(bus.rd2D), 64'h0);
    modelRegs[10] = 32'hCAFEF00D;
    modelInstret  = modelInstret + 64'd1;
    @(posedge CLK);
    #1;
    driveIdle();
    readBoth(5'd10, modelRegs[10], "nextcyc");
    check("nextcyc_instret", bus.instretW, modelInstret);

    // Reset asserted mid-cycle with a write to x12 pending; that write must be lost.
    bus.validW     = 1'b1;
    bus.regWriteW  = 1'b1;
    bus.aluResultW = 32'h12121212;
    bus.rdW        = 32'd12;
    @(negedge CLK);
    RST_N = 1'b0;
    resetModel();
    #1;
    check("midrst_instret", bus.instretW, 64'h0);
    for (int i = 1; i < 32; i++) begin
      bus.rs1D = 5'(i);
      bus.rs2D = 5'(i);
      #1;
      check($sformatf("midrst_rd1_x%0d", i), 64'(bus.rd1D), 64'h0);
    end
    readBoth(5'd12, 32'h0, "midrst_pending");

    // Release between edges; the still-driven write lands on the first edge after release.
    @(negedge CLK);
    RST_N = 1'b1;
    bus.rs1D = 5'd5;
    bus.rs2D = 5'd5;
    #1;
    check("rel_x5_cleared", 64'(bus.rd1D), 64'h0);
    @(posedge CLK);
    #1;
    driveIdle();
    modelRegs[12] = 32'h12121212;
    modelInstret  = 64'd1;
    readBoth(5'd12, modelRegs[12], "first_write");
    check("first_write_instret", bus.instretW, modelInstret);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
